// File: rtl/mdb_bus_controller_pkg.sv
// Shared definitions for the memory data bus (MDB) controller: FSM state
// encodings, the wait-state ceiling and the memory-control decode helper.
package mdb_bus_controller_pkg;

    // Largest number of memory wait cycles the controller supports.
    localparam int MDB_WAIT_MAX = 7;

    // FSM state encodings (plain constants for compatibility with legacy users).
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_XFER  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Memory-side control bundle.
    typedef struct packed {
        logic en;    // memory cycle active
        logic we;    // memory samples MDB as write data
        logic oe;    // memory drives MDB
        logic load;  // MDR releases MDB and captures it
    } mdb_ctrl_t;

    // Decode memory controls from a state and the latched direction. oe and
    // load are always produced together so the MDR never fights the memory.
    function automatic mdb_ctrl_t mdb_ctrl_decode(input logic [2:0] state,
                                                  input logic       is_write);
        mdb_ctrl_t c;
        c = '0;
        case (state)
            ST_SETUP: begin
                c.en = 1'b1;
            end
            ST_WAIT: begin
                c.en = 1'b1;
                if (is_write) begin
                    c.oe   = 1'b0;
                    c.load = 1'b0;
                end else begin
                    c.oe   = 1'b1;
                    c.load = 1'b1;
                end
            end
            ST_XFER: begin
                c.en = 1'b1;
                if (is_write) begin
                    c.we = 1'b1;
                end else begin
                    c.oe   = 1'b1;
                    c.load = 1'b1;
                end
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mdb_bus_controller_arbiter.sv
// Two-port round-robin arbiter. Bit 0 is the fetch port, bit 1 the data
// port. The pointer only moves when the controller accepts a grant.
module mdb_rr_arbiter
    import mdb_bus_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic prio_data_r;  // 1: data port wins a tie, 0: fetch port wins a tie

    // Pick one requester; on a tie the port not granted last time wins.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            if (prio_data_r) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end else if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

    // Advance the tie-break pointer past the port that was just accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_data_r <= 1'b0;
        end else if (accept && (grant != 2'b00)) begin
            prio_data_r <= grant[0];
        end else begin
            prio_data_r <= prio_data_r;
        end
    end

endmodule

// File: rtl/mdb_bus_controller.sv
// MDB bus controller: arbitrates the fetch and data ports onto one memory
// and sequences IDLE -> SETUP -> WAIT* -> XFER -> DONE. Every output is a
// register loaded from the next-state decode, so no request input reaches
// the memory controls combinationally.
module mdb_bus_controller
    import mdb_bus_controller_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_oe,
    output logic        mdr_load2,
    output logic        fetch_done,
    output logic        data_done,
    output logic        busy,
    output logic        grant_id
);

    // Clamp the wait-state count into the supported range.
    localparam int WS_EFF = (WAIT_STATES > MDB_WAIT_MAX) ? MDB_WAIT_MAX :
                            ((WAIT_STATES < 0) ? 0 : WAIT_STATES);
    localparam logic [2:0] WAIT_LOAD = (WS_EFF > 0) ? 3'(WS_EFF - 1) : 3'd0;
    localparam bit         SKIP_WAIT = (WS_EFF == 0);

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [2:0]  wait_cnt_r;
    logic [2:0]  wait_cnt_nxt_s;
    logic        is_write_r;
    logic        is_write_nxt_s;
    logic        grant_id_r;
    logic        grant_id_nxt_s;
    logic [15:0] mem_addr_r;
    logic [15:0] mem_addr_nxt_s;
    logic        mem_en_r;
    logic        mem_we_r;
    logic        mem_oe_r;
    logic        mdr_load2_r;
    logic        fetch_done_r;
    logic        data_done_r;
    logic        busy_r;
    logic [1:0]  req_s;
    logic [1:0]  grant_s;
    logic        accept_s;
    mdb_ctrl_t   ctrl_nxt_s;

    assign req_s = {data_req, fetch_req};

    mdb_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_s),
        .accept (accept_s),
        .grant  (grant_s)
    );

    // Next-state, grant latching and wait-counter sequencing.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        is_write_nxt_s = is_write_r;
        grant_id_nxt_s = grant_id_r;
        mem_addr_nxt_s = mem_addr_r;
        accept_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_s == 2'b10) begin
                    accept_s       = 1'b1;
                    state_nxt_s    = ST_SETUP;
                    grant_id_nxt_s = 1'b1;
                    mem_addr_nxt_s = data_addr;
                    is_write_nxt_s = data_we;
                end else if (grant_s == 2'b01) begin
                    accept_s       = 1'b1;
                    state_nxt_s    = ST_SETUP;
                    grant_id_nxt_s = 1'b0;
                    mem_addr_nxt_s = fetch_addr;
                    is_write_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (SKIP_WAIT) begin
                    state_nxt_s    = ST_XFER;
                    wait_cnt_nxt_s = 3'd0;
                end else begin
                    state_nxt_s    = ST_WAIT;
                    wait_cnt_nxt_s = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 3'd0) begin
                    state_nxt_s = ST_XFER;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r - 3'd1;
                end
            end
            ST_XFER: begin
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                state_nxt_s    = ST_IDLE;
                wait_cnt_nxt_s = 3'd0;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                wait_cnt_nxt_s = 3'd0;
            end
        endcase
        ctrl_nxt_s = mdb_ctrl_decode(state_nxt_s, is_write_nxt_s);
    end

    // State and registered outputs; reset aborts any transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= 3'd0;
            is_write_r   <= 1'b0;
            grant_id_r   <= 1'b0;
            mem_addr_r   <= 16'h0000;
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_oe_r     <= 1'b0;
            mdr_load2_r  <= 1'b0;
            fetch_done_r <= 1'b0;
            data_done_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            wait_cnt_r   <= wait_cnt_nxt_s;
            is_write_r   <= is_write_nxt_s;
            grant_id_r   <= grant_id_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_en_r     <= ctrl_nxt_s.en;
            mem_we_r     <= ctrl_nxt_s.we;
            mem_oe_r     <= ctrl_nxt_s.oe;
            mdr_load2_r  <= ctrl_nxt_s.load;
            fetch_done_r <= (state_nxt_s == ST_DONE) && !grant_id_nxt_s;
            data_done_r  <= (state_nxt_s == ST_DONE) && grant_id_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
        end
    end

    assign mem_addr   = mem_addr_r;
    assign mem_en     = mem_en_r;
    assign mem_we     = mem_we_r;
    assign mem_oe     = mem_oe_r;
    assign mdr_load2  = mdr_load2_r;
    assign fetch_done = fetch_done_r;
    assign data_done  = data_done_r;
    assign busy       = busy_r;
    assign grant_id   = grant_id_r;

endmodule

// File: tb/tb_mdb_bus_controller.sv
// Testbench for mdb_bus_controller: three instances (WAIT_STATES 1, 3, 0)
// share the requester inputs; a memory + MDR model follows the selected one.
module tb_mdb_bus_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;

    logic [15:0] mem_addr_a   [3];
    logic        mem_en_a     [3];
    logic        mem_we_a     [3];
    logic        mem_oe_a     [3];
    logic        mdr_load2_a  [3];
    logic        fetch_done_a [3];
    logic        data_done_a  [3];
    logic        busy_a       [3];
    logic        grant_id_a   [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mdb_bus_controller #(.WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0))) u_dut (
            .clk        (clk),
            .rst        (rst),
            .fetch_req  (fetch_req),
            .fetch_addr (fetch_addr),
            .data_req   (data_req),
            .data_we    (data_we),
            .data_addr  (data_addr),
            .mem_addr   (mem_addr_a[g]),
            .mem_en     (mem_en_a[g]),
            .mem_we     (mem_we_a[g]),
            .mem_oe     (mem_oe_a[g]),
            .mdr_load2  (mdr_load2_a[g]),
            .fetch_done (fetch_done_a[g]),
            .data_done  (data_done_a[g]),
            .busy       (busy_a[g]),
            .grant_id   (grant_id_a[g])
        );
    end

    // Selected instance view
    int          sel = 0;
    logic [15:0] s_addr;
    logic        s_en, s_we, s_oe, s_load, s_fd, s_dd, s_busy, s_gid;
    always_comb begin
        s_addr = mem_addr_a[sel];
        s_en   = mem_en_a[sel];
        s_we   = mem_we_a[sel];
        s_oe   = mem_oe_a[sel];
        s_load = mdr_load2_a[sel];
        s_fd   = fetch_done_a[sel];
        s_dd   = data_done_a[sel];
        s_busy = busy_a[sel];
        s_gid  = grant_id_a[sel];
    end

    // Memory and MDR environment model
    logic [15:0] mem_model [0:65535];
    logic [15:0] mdr = 16'h0000;
    logic [15:0] mdb;
    logic        pre_en = 1'b0;
    logic [15:0] pre_addr = 16'h0000;
    logic [15:0] pre_data = 16'h0000;
    logic        mdr_set = 1'b0;
    logic [15:0] mdr_val = 16'h0000;
    int          cyc = 0;

    assign mdb = s_oe ? mem_model[s_addr] : mdr;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_en) mem_model[pre_addr] <= pre_data;
        else if (s_en && s_we) mem_model[s_addr] <= mdb;
        if (mdr_set) mdr <= mdr_val;
        else if (s_load) mdr <= mdb;
    end

    // Scoreboard
    typedef struct {
        logic        port;
        logic [15:0] addr;
        logic [15:0] data;
        bit          chk_mdr;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int oe_cnt_last = 0;
    int we_cnt_last = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample #1 after the edge and check bus contention everywhere.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("contention", {31'd0, mem_oe_a[k] & ~mdr_load2_a[k]}, 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        step();
        pre_en   = 1'b0;
    endtask

    task automatic push(input logic p, input logic [15:0] a, input logic [15:0] d,
                        input bit cm, input int lat);
        exp_t e;
        e.port = p; e.addr = a; e.data = d; e.chk_mdr = cm; e.lat = lat;
        sb.push_back(e);
    endtask

    // Wait (bounded) for a done pulse, then pop and compare the expectation.
    task automatic wait_done(input int start, input int budget);
        exp_t e;
        bit   seen;
        int   oe_cnt;
        int   we_cnt;
        seen = 1'b0; oe_cnt = 0; we_cnt = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            oe_cnt = oe_cnt + (s_oe ? 1 : 0);
            we_cnt = we_cnt + (s_we ? 1 : 0);
            if (s_fd || s_dd) seen = 1'b1;
        end
        oe_cnt_last = oe_cnt;
        we_cnt_last = we_cnt;
        chk("done_seen", {31'd0, seen}, 32'd1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_port", {31'd0, s_dd}, {31'd0, e.port});
            chk("done_onehot", {31'd0, s_fd ^ s_dd}, 32'd1);
            chk("grant_id", {31'd0, s_gid}, {31'd0, e.port});
            chk("mem_addr", {16'd0, s_addr}, {16'd0, e.addr});
            if (e.lat >= 0) chk("latency", cyc - start, e.lat);
            if (e.chk_mdr) chk("mdr", {16'd0, mdr}, {16'd0, e.data});
        end else if (seen) begin
            chk("sb_nonempty", sb.size(), 32'd1);
        end
    endtask

    initial begin
        int start;
        rst = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        fetch_addr = 16'h0000; data_addr = 16'h0000;

        // Reset: every output of every instance is zero
        do_reset();
        for (int k = 0; k < 3; k++) begin
            chk("rst_addr", {16'd0, mem_addr_a[k]}, 32'd0);
            chk("rst_en",   {31'd0, mem_en_a[k]}, 32'd0);
            chk("rst_we",   {31'd0, mem_we_a[k]}, 32'd0);
            chk("rst_oe",   {31'd0, mem_oe_a[k]}, 32'd0);
            chk("rst_load", {31'd0, mdr_load2_a[k]}, 32'd0);
            chk("rst_fd",   {31'd0, fetch_done_a[k]}, 32'd0);
            chk("rst_dd",   {31'd0, data_done_a[k]}, 32'd0);
            chk("rst_busy", {31'd0, busy_a[k]}, 32'd0);
            chk("rst_gid",  {31'd0, grant_id_a[k]}, 32'd0);
        end
        preload(16'h0040, 16'hBEEF);
        preload(16'h0300, 16'h3333);
        preload(16'h0100, 16'h1111);
        preload(16'h0200, 16'h2222);
        preload(16'h0010, 16'hAAAA);
        preload(16'h0011, 16'h5555);

        // Fetch read WS=1; address change ignored; data request arriving mid-way waits
        sel = 0;
        do_reset();
        fetch_addr = 16'h0040; fetch_req = 1'b1;
        start = cyc;
        push(1'b0, 16'h0040, 16'hBEEF, 1'b1, 4);
        step();
        chk("setup_busy", {31'd0, s_busy}, 32'd1);
        chk("setup_en",   {31'd0, s_en}, 32'd1);
        chk("setup_oe",   {31'd0, s_oe}, 32'd0);
        chk("setup_addr", {16'd0, s_addr}, 32'h0040);
        fetch_addr = 16'hFFFF;
        data_addr = 16'h0300; data_we = 1'b0; data_req = 1'b1;
        push(1'b1, 16'h0300, 16'h3333, 1'b1, -1);
        wait_done(start, 10);
        chk("fetch_oe_cycles", oe_cnt_last, 32'd2);
        fetch_req = 1'b0;
        wait_done(cyc, 12);
        data_req = 1'b0;

        // Data write WS=1
        do_reset();
        mdr_val = 16'h00A5; mdr_set = 1'b1;
        step();
        mdr_set = 1'b0;
        data_addr = 16'h1234; data_we = 1'b1; data_req = 1'b1;
        push(1'b1, 16'h1234, 16'h0000, 1'b0, 4);
        wait_done(cyc, 10);
        data_req = 1'b0;
        chk("wr_we_cycles", we_cnt_last, 32'd1);
        chk("wr_oe_cycles", oe_cnt_last, 32'd0);
        chk("wr_mem", {16'd0, mem_model[16'h1234]}, 32'h00A5);
        step();
        step();
        chk("wr_single_done", {30'd0, s_fd, s_dd}, 32'd0);
        chk("wr_idle", {31'd0, s_busy}, 32'd0);
        data_we = 1'b0;

        // Round-robin with both requests held: fetch, data, fetch
        do_reset();
        fetch_addr = 16'h0100; data_addr = 16'h0200; data_we = 1'b0;
        fetch_req = 1'b1; data_req = 1'b1;
        push(1'b0, 16'h0100, 16'h1111, 1'b1, -1);
        push(1'b1, 16'h0200, 16'h2222, 1'b1, -1);
        push(1'b0, 16'h0100, 16'h1111, 1'b1, -1);
        for (int t = 0; t < 3; t++) wait_done(cyc, 12);
        fetch_req = 1'b0; data_req = 1'b0;

        // Reset during WAIT with WS=3: no done, controls released
        sel = 1;
        do_reset();
        fetch_addr = 16'h0040; fetch_req = 1'b1;
        step(); step(); step();
        chk("mid_wait_busy", {31'd0, s_busy}, 32'd1);
        chk("mid_wait_oe",   {31'd0, s_oe}, 32'd1);
        rst = 1'b1; fetch_req = 1'b0;
        step();
        rst = 1'b0;
        chk("abort_busy", {31'd0, s_busy}, 32'd0);
        chk("abort_oe",   {31'd0, s_oe}, 32'd0);
        chk("abort_load", {31'd0, s_load}, 32'd0);
        chk("abort_en",   {31'd0, s_en}, 32'd0);
        chk("abort_addr", {16'd0, s_addr}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_no_done", {30'd0, s_fd, s_dd}, 32'd0);
        end

        // WS=0 back-to-back reads with the request left high
        sel = 2;
        do_reset();
        fetch_addr = 16'h0010; fetch_req = 1'b1;
        push(1'b0, 16'h0010, 16'hAAAA, 1'b1, 3);
        wait_done(cyc, 8);
        fetch_addr = 16'h0011;
        step();
        chk("b2b_idle", {31'd0, s_busy}, 32'd0);
        push(1'b0, 16'h0011, 16'h5555, 1'b1, 3);
        wait_done(cyc, 8);
        fetch_req = 1'b0;
        step();
        step();
        chk("b2b_no_extra", {31'd0, s_busy}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mdb_bus_controller.md
MDB_BUS_CONTROLLER -- requirements
Module: mdb_bus_controller

Interface
REQ-001 WAIT_STATES, default 1, memory wait cycles per access; legal range 0..7.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 fetch_req  input  1  instruction-fetch read request, level, held until fetch_done.
REQ-005 fetch_addr  input  16  fetch address.
REQ-006 data_req  input  1  data-access request, level, held until data_done.
REQ-007 data_we  input  1  data access direction: 1 write, 0 read.
REQ-008 data_addr  input  16  data address.
REQ-009 mem_addr  output  16  registered address to memory.
REQ-010 mem_en  output  1  memory cycle active.
REQ-011 mem_we  output  1  memory samples MDB as write data.
REQ-012 mem_oe  output  1  memory drives MDB.
REQ-013 mdr_load2  output  1  MDR releases MDB and captures it at the clock edge.
REQ-014 fetch_done  output  1  one-cycle completion pulse for the fetch port.
REQ-015 data_done  output  1  one-cycle completion pulse for the data port.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 grant_id  output  1  owner of the current transaction: 0 fetch, 1 data.

Function
REQ-018 The FSM SHALL have the states IDLE, SETUP, WAIT, XFER and DONE.
REQ-019 In IDLE with any request, the controller SHALL grant, latch the address into mem_addr, latch the direction (fetch is always a read), set grant_id, and go to SETUP.
REQ-020 Arbitration when both requests are present SHALL be round-robin against the last granted port; after reset, fetch wins first.
REQ-021 SETUP SHALL last 1 cycle, with mem_en=1 and mem_we=mem_oe=mdr_load2=0.
REQ-022 WAIT SHALL last exactly WAIT_STATES cycles and SHALL be skipped when WAIT_STATES=0; a wait counter counts down from WAIT_STATES-1 to 0.
REQ-023 Read cycles in WAIT and XFER SHALL drive mem_en=1, mem_oe=1 and mdr_load2=1; the MDR captures MDB at the clock edge that ends XFER.
REQ-024 Write cycles in WAIT and XFER SHALL drive mem_en=1, mem_we=1 (XFER only) and mem_oe=mdr_load2=0, so the MDR drives MDB.
REQ-025 Bus-contention invariant: mem_oe=1 SHALL imply mdr_load2=1 in the same cycle, in every state and under reset.
REQ-026 XFER SHALL last 1 cycle and then go to DONE.
REQ-027 DONE SHALL last 1 cycle, pulse the done output of the granted port, keep all memory controls at 0, and return to IDLE.
REQ-028 Latency from the request being sampled in IDLE to the done pulse SHALL be WAIT_STATES+3 cycles; the done pulse appears in the (WAIT_STATES+4)th cycle.
REQ-029 A requester SHALL deassert req in the cycle after done; a request still high in IDLE SHALL start a new transaction, subject to arbitration.
REQ-030 Request and address changes after the grant SHALL be ignored until IDLE.
REQ-031 A request arriving during a transaction SHALL wait; it is not lost while held.
REQ-032 All outputs SHALL be registered or decoded only from state; there is no combinational path from any req to memory controls.

Reset
REQ-033 rst SHALL force IDLE at the next edge from any state, including mid-WAIT and mid-XFER.
REQ-034 Reset values: mem_addr=0; mem_en=mem_we=mem_oe=mdr_load2=0; fetch_done=data_done=0; busy=0; grant_id=0; wait counter=0; round-robin pointer=favor fetch.
REQ-035 A transaction aborted by reset SHALL NOT produce a done pulse.

Structure
REQ-036 The state encoding constants and the WAIT_STATES legal maximum SHALL live in the shared CPU package.
REQ-037 The round-robin arbiter SHALL be a sub-module, mdb_rr_arbiter, with two requests, a one-hot grant and a pointer update on accept.
REQ-038 The total implementation size SHALL be 120-400 RTL lines.

Verification
REQ-039 Reset: with rst high for 2 cycles, all outputs SHALL be 0 and busy SHALL be 0.
REQ-040 Fetch read, WAIT_STATES=1, fetch_addr=16'h0040, memory returns 16'hBEEF: mem_oe and mdr_load2 are high for 2 cycles, fetch_done pulses 4 cycles after the grant, and the MDR holds 16'hBEEF.
REQ-041 Data write, data_addr=16'h1234, MDR=16'h00A5: mem_we is high only in XFER, mem_oe=0 throughout, memory[16'h1234]=16'h00A5, and data_done pulses once.
REQ-042 Simultaneous fetch_req and data_req held continuously: grants SHALL alternate fetch, data, fetch, and each done pulse matches grant_id.
REQ-043 rst asserted during WAIT (WAIT_STATES=3): the next cycle is IDLE, no done pulse occurs, mem_oe=0 and mdr_load2=0.
REQ-044 WAIT_STATES=0 back-to-back reads: done SHALL arrive 3 cycles after each grant, and the bench SHALL assert the contention invariant in every cycle.
